// File: rtl/march_bist_pkg.sv
// rtl/march_bist_pkg.sv - March C- state encoding and per-element tables
package march_bist_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    localparam int NUM_ELEMS = 6;

    // Bit e describes element e: up(w0) up(r0,w1) up(r1,w0) down(r0,w1) down(r1,w0) up(r0)
    localparam logic [7:0] ELEM_DOWN      = 8'b0001_1000;
    localparam logic [7:0] ELEM_HAS_READ  = 8'b0011_1110;
    localparam logic [7:0] ELEM_HAS_WRITE = 8'b0001_1111;
    localparam logic [7:0] ELEM_READ_BG   = 8'b0001_0100;
    localparam logic [7:0] ELEM_WRITE_BG  = 8'b0000_1010;

endpackage

// File: rtl/march_bist_ctrl_if.sv
// rtl/march_bist_ctrl_if.sv - single-port memory bus between BIST engine and memory under test
interface march_bist_ctrl_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
);
    logic                  write_read;
    logic [ADDR_WIDTH-1:0] address;
    logic [DATA_WIDTH-1:0] wdata;
    logic [DATA_WIDTH-1:0] rdata;

    modport master (output write_read, output address, output wdata, input rdata);
    modport slave  (input write_read, input address, input wdata, output rdata);
endinterface

// File: rtl/bist_rd_checker.sv
// rtl/bist_rd_checker.sv - read tag pipeline, comparator, first-fail capture, error counter
module bist_rd_checker #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int RD_LAT     = 2,
    parameter int ERR_W      = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_exp,
    input  logic [ADDR_WIDTH-1:0] push_addr,
    input  logic [2:0]            push_elem,
    input  logic [DATA_WIDTH-1:0] rdata,
    output logic                  fail,
    output logic [ADDR_WIDTH-1:0] fail_addr,
    output logic [DATA_WIDTH-1:0] fail_data,
    output logic [2:0]            fail_elem,
    output logic [ERR_W-1:0]      err_count
);
    logic [RD_LAT-1:0]     tag_valid;
    logic [DATA_WIDTH-1:0] tag_exp  [RD_LAT];
    logic [ADDR_WIDTH-1:0] tag_addr [RD_LAT];
    logic [2:0]            tag_elem [RD_LAT];
    logic                  mismatch;

    always_ff @(posedge clk) begin
        if (rst) begin
            tag_valid <= '0;
        end else begin
            tag_valid[0] <= push;
            for (int i = 1; i < RD_LAT; i++) tag_valid[i] <= tag_valid[i-1];
        end
    end

    always_ff @(posedge clk) begin
        tag_exp[0]  <= push_exp;
        tag_addr[0] <= push_addr;
        tag_elem[0] <= push_elem;
        for (int i = 1; i < RD_LAT; i++) begin
            tag_exp[i]  <= tag_exp[i-1];
            tag_addr[i] <= tag_addr[i-1];
            tag_elem[i] <= tag_elem[i-1];
        end
    end

    // The output stage lines up with rdata for the read that pushed it
    assign mismatch = tag_valid[RD_LAT-1] && (rdata != tag_exp[RD_LAT-1]);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            fail      <= 1'b0;
            fail_addr <= '0;
            fail_data <= '0;
            fail_elem <= '0;
            err_count <= '0;
        end else if (mismatch) begin
            if (err_count != '1) err_count <= err_count + ERR_W'(1);
            if (!fail) begin
                fail      <= 1'b1;
                fail_addr <= tag_addr[RD_LAT-1];
                fail_data <= rdata;
                fail_elem <= tag_elem[RD_LAT-1];
            end
        end
    end
endmodule

// File: rtl/march_bist_ctrl.sv
// rtl/march_bist_ctrl.sv - March C- BIST sequencer driving a single-port memory
module march_bist_ctrl
    import march_bist_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int CAPACITY   = 16,
    parameter int RD_LAT     = 2,
    parameter int ERR_W      = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    march_bist_ctrl_if.master     mem,
    output logic                  busy,
    output logic                  done,
    output logic                  fail,
    output logic [ADDR_WIDTH-1:0] fail_addr,
    output logic [DATA_WIDTH-1:0] fail_data,
    output logic [2:0]            fail_elem,
    output logic [ERR_W-1:0]      err_count
);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR  = ADDR_WIDTH'(CAPACITY - 1);
    localparam logic [2:0]            LAST_ELEM  = 3'(NUM_ELEMS - 1);
    localparam int                    DCW        = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam logic [DCW-1:0]        DRAIN_LAST = DCW'(RD_LAT - 1);

    state_t                state, state_n;
    logic [2:0]            elem, elem_n, next_elem;
    logic [ADDR_WIDTH-1:0] addr, addr_n, next_start;
    logic                  op, op_n;
    logic [DCW-1:0]        drain, drain_n;
    logic                  clear, push, rd_op, op_last, at_end;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            elem  <= '0;
            addr  <= '0;
            op    <= 1'b0;
            drain <= '0;
        end else begin
            state <= state_n;
            elem  <= elem_n;
            addr  <= addr_n;
            op    <= op_n;
            drain <= drain_n;
        end
    end

    always_comb begin
        state_n        = state;
        elem_n         = elem;
        addr_n         = addr;
        op_n           = op;
        drain_n        = drain;
        clear          = 1'b0;
        push           = 1'b0;
        busy           = 1'b0;
        done           = 1'b0;
        mem.write_read = 1'b0;
        mem.address    = '0;
        mem.wdata      = '0;
        rd_op          = ELEM_HAS_READ[elem] && !op;
        op_last        = op || !(ELEM_HAS_READ[elem] && ELEM_HAS_WRITE[elem]);
        // Terminating on the boundary address keeps the counter from wrapping
        at_end         = ELEM_DOWN[elem] ? (addr == '0) : (addr == LAST_ADDR);
        next_elem      = (state == S_RUN) ? elem + 3'd1 : 3'd0;
        next_start     = ELEM_DOWN[next_elem] ? LAST_ADDR : '0;

        case (state)
            S_IDLE, S_DONE: begin
                done = (state == S_DONE);
                if (start) begin
                    clear   = 1'b1;
                    state_n = S_SETUP;
                    elem_n  = next_elem;
                    addr_n  = next_start;
                    op_n    = 1'b0;
                end
            end
            S_SETUP: begin
                busy        = 1'b1;
                mem.address = addr;
                mem.wdata   = {DATA_WIDTH{ELEM_WRITE_BG[elem]}};
                op_n        = 1'b0;
                state_n     = S_RUN;
            end
            S_RUN: begin
                busy           = 1'b1;
                mem.address    = addr;
                mem.wdata      = {DATA_WIDTH{ELEM_WRITE_BG[elem]}};
                mem.write_read = !rd_op;
                push           = rd_op;
                if (op_last) begin
                    op_n = 1'b0;
                    if (at_end) begin
                        if (elem == LAST_ELEM) begin
                            state_n = S_DRAIN;
                            drain_n = '0;
                        end else begin
                            elem_n  = next_elem;
                            addr_n  = next_start;
                            state_n = S_SETUP;
                        end
                    end else begin
                        addr_n = ELEM_DOWN[elem] ? addr - ADDR_WIDTH'(1) : addr + ADDR_WIDTH'(1);
                    end
                end else begin
                    op_n = 1'b1;
                end
            end
            S_DRAIN: begin
                busy = 1'b1;
                if (drain == DRAIN_LAST) state_n = S_DONE;
                else                     drain_n = drain + DCW'(1);
            end
            default: state_n = S_IDLE;
        endcase
    end

    bist_rd_checker #(
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH),
        .RD_LAT    (RD_LAT),
        .ERR_W     (ERR_W)
    ) u_checker (
        .clk      (clk),
        .rst      (rst),
        .clear    (clear),
        .push     (push),
        .push_exp ({DATA_WIDTH{ELEM_READ_BG[elem]}}),
        .push_addr(addr),
        .push_elem(elem),
        .rdata    (mem.rdata),
        .fail     (fail),
        .fail_addr(fail_addr),
        .fail_data(fail_data),
        .fail_elem(fail_elem),
        .err_count(err_count)
    );
endmodule

// File: doc/march_bist_ctrl.md
Name: march_bist_ctrl

Overview:
- MBIST engine that drives the single-port fault-memory model through its write_read/address/wdata/rdata interface.
- Runs a March C- sequence, compares every read against the expected background and reports pass/fail plus the first failing location.
- Sits between the test top and the memory under test; the memory itself is unchanged.

Parameters:
- DATA_WIDTH, 8, memory word width.
- ADDR_WIDTH, 4, memory address width.
- CAPACITY, 16, number of words tested; addresses 0..CAPACITY-1 (CAPACITY <= 2**ADDR_WIDTH).
- RD_LAT, 2, edges from read address sample to rdata valid.
- ERR_W, 8, error counter width.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  level; sampled only in IDLE or DONE.
- write_read  out  1  1 = write, 0 = read; to memory.
- address  out  ADDR_WIDTH  memory address.
- wdata  out  DATA_WIDTH  write data. Memory registers it one cycle before use, so it is driven one cycle ahead of the write.
- rdata  in  DATA_WIDTH  memory read data; valid RD_LAT edges after the read address.
- busy  out  1  high in SETUP/RUN/DRAIN.
- done  out  1  high in DONE until the next start.
- fail  out  1  sticky; set on the first mismatch.
- fail_addr  out  ADDR_WIDTH  address of the first mismatch.
- fail_data  out  DATA_WIDTH  rdata of the first mismatch.
- fail_elem  out  3  march element index (0..5) of the first mismatch.
- err_count  out  ERR_W  total mismatches; saturates at all-ones.

Behaviour:
- Reset (sync, rst=1 at edge): all outputs 0, state IDLE. Applies mid-run too: the run is abandoned, the pipeline is flushed and there is no done pulse.
- March C- elements:
  - E0 up(w0)
  - E1 up(r0,w1)
  - E2 up(r1,w0)
  - E3 down(r0,w1)
  - E4 down(r1,w0)
  - E5 up(r0)
- Backgrounds: 0 = all zeros, 1 = all ones.
- Up runs 0 to CAPACITY-1; down runs CAPACITY-1 to 0.
- States:
  - IDLE: start=1 -> SETUP. Clears fail, fail_* and err_count; elem=0.
  - SETUP: 1 cycle. write_read=0, address=element start, wdata=element write value. -> RUN.
  - RUN: per address, issue the element's ops in order, one op per cycle.
    - Read-then-write ops share the address; the address advances after the last op.
    - wdata holds the element write value throughout, which satisfies the one-cycle wdata lead.
    - After the last op at the last address: elem<5 -> SETUP with elem+1; elem=5 -> DRAIN.
  - DRAIN: RD_LAT cycles, write_read=0, no new reads checked. -> DONE.
  - DONE: done=1, busy=0. start=1 -> SETUP (restart, status cleared as in IDLE).
- The SETUP read at the element start address is a dummy: it is not tagged for checking.
- Check pipeline:
  - Each RUN read pushes {valid, expected, address, elem} into an RD_LAT-deep shift register.
  - At the output stage, valid and rdata != expected -> err_count++ (saturating).
  - If fail=0 on that mismatch: set fail and capture address/rdata/elem.
  - Later mismatches do not overwrite the captured values.
- Cycle count: busy is high for exactly 10*CAPACITY + 6 + RD_LAT cycles. done rises the cycle after busy falls.
- start while busy: ignored.
- write_read is never 1 outside RUN.
- CAPACITY=1: each element has one address, with no wrap or underflow of the address counter.
- The down address counter must not wrap below 0 at the element end; the element terminates at 0.

Decomposition:
- Package march_bist_pkg holds:
  - state encoding (IDLE, SETUP, RUN, DRAIN, DONE);
  - element count 6;
  - per-element tables: direction, op list, read expected background, write background.
- Sub-module bist_rd_checker holds the RD_LAT-deep tag pipeline, comparator, first-fail capture and saturating err_count. Interface: push tag in; status out; clear.

Test Plan:
- Fault-free memory, CAPACITY=16, start pulse -> busy exactly 168 cycles, then done=1, fail=0, err_count=0.
- Word 3 bit 5 stuck-at-0 -> fail=1, fail_addr=3, fail_elem=2, fail_data=8'hDF, err_count=2 (E2 r1 and E4 r1).
- Coupling fault at WRONG_ADDR=5 (bit 5 forced 0 on write when neighbour pattern 4'b0101) -> fail=1, fail_addr=5; err_count matches the golden march model.
- rst asserted 20 cycles into RUN -> next cycle all outputs 0 and IDLE; a new start gives a clean 168-cycle pass.
- start held high through the run and into DONE -> no effect while busy; from DONE, restarts and clears status in the same cycle as SETUP entry.
- Waveform check: in every write cycle, wdata in the preceding cycle equals the element write background; no write_read=1 in SETUP or DRAIN.
